// File: rtl/ldmx_dma_pkg.sv
// Shared types and constants for the DMA inbound stream arbiter and later link merges.
package ldmx_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } dma_state_t;

  localparam int DATA_W_DEF      = 64;
  localparam int CNT_W_DEF       = 16;
  localparam int TDEST_W         = 8;
  localparam int TUSER_W         = 64;
  localparam int TUSER_TRUNC_BIT = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after (ptr+1) mod N, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  int  cand;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC readout streams onto the DMA inbound stream,
// with source tagging on tDest, runtime length limiting and per-source frame counters.
module dma_stream_arbiter
  import ldmx_dma_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      dmaClk,
  input  logic                      dmaRst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC-1:0]        src_enable,
  input  logic [CNT_W-1:0]          max_beats,
  output logic                      dmaIbMaster_tValid,
  output logic [DATA_W-1:0]         dmaIbMaster_tData,
  output logic                      dmaIbMaster_tLast,
  output logic [TDEST_W-1:0]        dmaIbMaster_tDest,
  output logic [TUSER_W-1:0]        dmaIbMaster_tUser,
  input  logic                      dmaIbSlave_tReady,
  output logic [NUM_SRC*CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]          trunc_cnt,
  output logic                      active,
  output dma_state_t                state_dbg
);

  localparam int IDX_W = $clog2(NUM_SRC);

  // Handshake: a beat moves on a clock edge where valid and ready are both high;
  // valid never waits on ready, and ready to the granted source is tReady passed through.
  dma_state_t       state, state_nxt;
  logic [IDX_W-1:0] grant, ptr, arb_idx;
  logic [NUM_SRC-1:0] arb_gnt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] frame_q [NUM_SRC];
  logic             req_any, cur_last, limit_hit, beat_acc;

  rr_arbiter #(.N(NUM_SRC), .IDX_W(IDX_W)) u_rr (
    .req (src_valid & src_enable),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign req_any   = |arb_gnt;
  assign cur_last  = src_last[grant];
  assign limit_hit = (max_beats != '0) && (beat_cnt == max_beats - CNT_W'(1));
  assign beat_acc  = (state == PASS) && src_valid[grant] && dmaIbSlave_tReady;

  always_ff @(posedge dmaClk) begin
    if (dmaRst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      beat_cnt  <= '0;
      trunc_cnt <= '0;
      for (int i = 0; i < NUM_SRC; i++) frame_q[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_any) begin
        grant    <= arb_idx;
        beat_cnt <= '0;
      end
      if (beat_acc) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (cur_last || limit_hit) begin
          frame_q[grant] <= frame_q[grant] + CNT_W'(1);
          ptr            <= grant;
          if (limit_hit && !cur_last && trunc_cnt != '1)
            trunc_cnt <= trunc_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = PASS;
      PASS: begin
        if (beat_acc && cur_last)       state_nxt = IDLE;
        else if (beat_acc && limit_hit) state_nxt = DRAIN;
      end
      DRAIN:   if (src_valid[grant] && cur_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmaIbMaster_tValid = 1'b0;
    dmaIbMaster_tData  = '0;
    dmaIbMaster_tLast  = 1'b0;
    dmaIbMaster_tDest  = '0;
    dmaIbMaster_tUser  = '0;
    src_ready          = '0;
    case (state)
      PASS: begin
        dmaIbMaster_tValid = src_valid[grant];
        dmaIbMaster_tData  = src_data[int'(grant)*DATA_W +: DATA_W];
        dmaIbMaster_tLast  = cur_last | limit_hit;
        dmaIbMaster_tDest  = TDEST_W'(grant);
        dmaIbMaster_tUser[TUSER_TRUNC_BIT] = limit_hit & ~cur_last;
        src_ready[grant]   = dmaIbSlave_tReady;
      end
      DRAIN:   src_ready[grant] = 1'b1;
      default: ;
    endcase
  end

  assign active    = (state != IDLE);
  assign state_dbg = state;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_frame
    assign frame_cnt[i*CNT_W +: CNT_W] = frame_q[i];
  end

endmodule

// File: tb/tb_dma_stream_arbiter.sv
// Directed bench for dma_stream_arbiter: per-source beat queues, observed/expected beat queues.
module tb_dma_stream_arbiter;
  import ldmx_dma_pkg::*;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_valid, src_last, src_ready, src_enable;
  logic [NS*DW-1:0]  src_data;
  logic [CW-1:0]     max_beats;
  logic              t_valid, t_last, t_ready;
  logic [DW-1:0]     t_data;
  logic [7:0]        t_dest;
  logic [63:0]       t_user;
  logic [NS*CW-1:0]  frame_cnt;
  logic [CW-1:0]     trunc_cnt;
  logic              active;
  dma_state_t        state_dbg;

  always #5 clk = ~clk;

  dma_stream_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .CNT_W(CW)) dut (
    .dmaClk(clk), .dmaRst(rst),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready), .src_enable(src_enable), .max_beats(max_beats),
    .dmaIbMaster_tValid(t_valid), .dmaIbMaster_tData(t_data),
    .dmaIbMaster_tLast(t_last), .dmaIbMaster_tDest(t_dest),
    .dmaIbMaster_tUser(t_user), .dmaIbSlave_tReady(t_ready),
    .frame_cnt(frame_cnt), .trunc_cnt(trunc_cnt), .active(active),
    .state_dbg(state_dbg)
  );

  int tests = 0;
  int fails = 0;
  logic [64:0] sq [NS][$];
  logic [73:0] obs_q[$];
  logic [73:0] exp_q[$];
  int src_acc [NS];
  int idle_cnt, ready_err, user_err, first_beat_cyc, en_clr_cyc;
  bit toggle_rdy;
  bit to;

  task automatic drive_inputs();
    logic [64:0] e;
    for (int i = 0; i < NS; i++) begin
      if (sq[i].size() > 0) begin
        e = sq[i][0];
        src_valid[i] = 1'b1;
        src_last[i]  = e[64];
        src_data[i*DW +: DW] = e[63:0];
      end else begin
        src_valid[i] = 1'b0;
        src_last[i]  = 1'b0;
        src_data[i*DW +: DW] = '0;
      end
    end
    t_ready = toggle_rdy ? ~t_ready : 1'b1;
  endtask

  task automatic push_pkt(input int s, input int n, input logic [63:0] base);
    for (int b = 1; b <= n; b++) sq[s].push_back({(b == n), base + 64'(b)});
  endtask

  task automatic exp_beat(input int s, input bit l, input bit u, input logic [63:0] d);
    exp_q.push_back({8'(s), l, u, d});
  endtask

  task automatic clear_sb();
    obs_q.delete();
    exp_q.delete();
    idle_cnt = 0; ready_err = 0; first_beat_cyc = -1;
    for (int i = 0; i < NS; i++) src_acc[i] = 0;
  endtask

  // Runs until the DUT is back in IDLE with every enabled source queue empty, or the budget expires.
  task automatic run(input int max_cyc, output bit timed_out);
    int c;
    bit done;
    logic [NS-1:0] acc, exp_rdy;
    bit empty;
    c = 0; timed_out = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (t_valid && t_ready) begin
        obs_q.push_back({t_dest, t_last, t_user[0], t_data});
        if (first_beat_cyc < 0) first_beat_cyc = c;
      end
      if (t_user[63:1] != '0) user_err++;
      exp_rdy = t_ready ? (NS'(1) << t_dest[1:0]) : '0;
      if (state_dbg == PASS && src_ready !== exp_rdy) ready_err++;
      if (!active) idle_cnt++;
      acc = src_valid & src_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++)
        if (acc[i]) begin void'(sq[i].pop_front()); src_acc[i]++; end
      c++;
      if (c == en_clr_cyc) src_enable[0] = 1'b0;
      drive_inputs();
      empty = 1;
      for (int i = 0; i < NS; i++) if (src_enable[i] && sq[i].size() > 0) empty = 0;
      done = (state_dbg == IDLE) && empty;
      if (!done && c >= max_cyc) begin timed_out = 1; done = 1; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NS; i++) sq[i].delete();
    toggle_rdy = 0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = '1; src_last = '1; src_data = '1; t_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (t_valid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b exp 0", t_valid); end
    tests++; if (t_last !== 1'b0) begin fails++; $display("FAIL reset_tlast got %b exp 0", t_last); end
    tests++; if (t_dest !== 8'h0 || t_user !== 64'h0 || t_data !== 64'h0) begin
      fails++; $display("FAIL reset_side got dest %h user %h data %h exp 0", t_dest, t_user, t_data); end
    tests++; if (src_ready !== '0) begin fails++; $display("FAIL reset_src_ready got %b exp 0", src_ready); end
    tests++; if (active !== 1'b0 || state_dbg !== IDLE) begin
      fails++; $display("FAIL reset_state got active %b state %0d exp 0/IDLE", active, state_dbg); end
    tests++; if (frame_cnt !== '0 || trunc_cnt !== '0) begin
      fails++; $display("FAIL reset_counters got frame %h trunc %h exp 0", frame_cnt, trunc_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    clear_sb();
    push_pkt(2, 4, 64'h0);
    for (int b = 1; b <= 4; b++) exp_beat(2, b == 4, 0, 64'(b));
    drive_inputs();
    run(40, to);
    tests++; if (to) begin fails++; $display("FAIL single_timeout got timeout exp done"); end
    tests++; if (first_beat_cyc != 1) begin fails++; $display("FAIL single_latency got %0d exp 1", first_beat_cyc); end
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      tests++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL single_beat%0d got %h exp %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]); end
    end
    tests++; if (frame_cnt[2*CW +: CW] !== 16'd1) begin fails++; $display("FAIL single_frame2 got %0d exp 1", frame_cnt[2*CW +: CW]); end
    tests++; if (idle_cnt != 1 || active !== 1'b0) begin fails++; $display("FAIL single_idle got %0d/%b exp 1/0", idle_cnt, active); end
  endtask

  task automatic test_fairness();
    do_reset();
    clear_sb();
    push_pkt(3, 2, 64'h9000);
    drive_inputs();
    run(40, to);
    clear_sb();
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < 2; p++) push_pkt(s, 2, 64'(s * 256 + p * 16));
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++)
        for (int b = 1; b <= 2; b++) exp_beat(s, b == 2, 0, 64'(s * 256 + p * 16 + b));
    drive_inputs();
    run(100, to);
    tests++; if (to) begin fails++; $display("FAIL fair_timeout got timeout exp done"); end
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL fair_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      tests++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL fair_beat%0d got %h exp %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]); end
    end
    tests++; if (idle_cnt != 8) begin fails++; $display("FAIL fair_idle_cycles got %0d exp 8", idle_cnt); end
    tests++; if (frame_cnt !== {16'd3, 16'd2, 16'd2, 16'd2}) begin fails++; $display("FAIL fair_frames got %h exp 0003000200020002", frame_cnt); end
    tests++; if (ready_err != 0) begin fails++; $display("FAIL fair_ready got %0d errors exp 0", ready_err); end
  endtask

  task automatic test_truncate();
    do_reset();
    clear_sb();
    max_beats = 16'd3;
    push_pkt(1, 6, 64'hA0);
    for (int b = 1; b <= 3; b++) exp_beat(1, b == 3, b == 3, 64'hA0 + 64'(b));
    drive_inputs();
    run(40, to);
    tests++; if (to) begin fails++; $display("FAIL trunc_timeout got timeout exp done"); end
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL trunc_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      tests++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL trunc_beat%0d got %h exp %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]); end
    end
    tests++; if (src_acc[1] != 6) begin fails++; $display("FAIL trunc_drained got %0d exp 6", src_acc[1]); end
    tests++; if (trunc_cnt !== 16'd1 || frame_cnt[CW +: CW] !== 16'd1) begin
      fails++; $display("FAIL trunc_counters got trunc %0d frame1 %0d exp 1/1", trunc_cnt, frame_cnt[CW +: CW]); end
  endtask

  task automatic test_exact_limit();
    clear_sb();
    push_pkt(1, 3, 64'hB0);
    for (int b = 1; b <= 3; b++) exp_beat(1, b == 3, 0, 64'hB0 + 64'(b));
    drive_inputs();
    run(40, to);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL exact_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      tests++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL exact_beat%0d got %h exp %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]); end
    end
    tests++; if (trunc_cnt !== 16'd1 || frame_cnt[CW +: CW] !== 16'd2) begin
      fails++; $display("FAIL exact_counters got trunc %0d frame1 %0d exp 1/2", trunc_cnt, frame_cnt[CW +: CW]); end
  endtask

  task automatic test_max_one();
    clear_sb();
    max_beats = 16'd1;
    push_pkt(0, 1, 64'hC0);
    push_pkt(0, 2, 64'hD0);
    exp_beat(0, 1, 0, 64'hC1);
    exp_beat(0, 1, 1, 64'hD1);
    drive_inputs();
    run(40, to);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL max1_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      tests++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL max1_beat%0d got %h exp %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]); end
    end
    tests++; if (trunc_cnt !== 16'd2 || frame_cnt[0 +: CW] !== 16'd2 || src_acc[0] != 3) begin
      fails++; $display("FAIL max1_counters got trunc %0d frame0 %0d acc %0d exp 2/2/3", trunc_cnt, frame_cnt[0 +: CW], src_acc[0]); end
    max_beats = '0;
  endtask

  task automatic test_ready_toggle();
    clear_sb();
    toggle_rdy = 1;
    push_pkt(3, 4, 64'hE0);
    for (int b = 1; b <= 4; b++) exp_beat(3, b == 4, 0, 64'hE0 + 64'(b));
    drive_inputs();
    run(40, to);
    toggle_rdy = 0;
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL toggle_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      tests++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL toggle_beat%0d got %h exp %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]); end
    end
    tests++; if (ready_err != 0 || src_acc[3] != 4) begin
      fails++; $display("FAIL toggle_ready got %0d errors acc %0d exp 0/4", ready_err, src_acc[3]); end
  endtask

  task automatic test_enable_and_reset();
    clear_sb();
    push_pkt(0, 4, 64'hF0);
    for (int b = 1; b <= 4; b++) exp_beat(0, b == 4, 0, 64'hF0 + 64'(b));
    en_clr_cyc = 2;
    drive_inputs();
    run(40, to);
    en_clr_cyc = -1;
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL disable_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      tests++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        fails++; $display("FAIL disable_beat%0d got %h exp %h", k, (k < obs_q.size()) ? obs_q[k] : '1, exp_q[k]); end
    end
    clear_sb();
    push_pkt(0, 2, 64'h500);
    push_pkt(1, 2, 64'h510);
    for (int b = 1; b <= 2; b++) exp_beat(1, b == 2, 0, 64'h510 + 64'(b));
    drive_inputs();
    run(40, to);
    tests++; if (obs_q.size() != exp_q.size() || (obs_q.size() > 0 && obs_q[0] !== exp_q[0])) begin
      fails++; $display("FAIL disabled_skip got %0d beats first %h exp 2 first %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '1, exp_q[0]); end
    tests++; if (src_acc[0] != 0 || sq[0].size() != 2) begin
      fails++; $display("FAIL disabled_untouched got acc %0d left %0d exp 0/2", src_acc[0], sq[0].size()); end
    sq[0].delete();
    src_enable = '1;
    clear_sb();
    push_pkt(2, 4, 64'h700);
    drive_inputs();
    run(3, to);
    tests++; if (state_dbg !== PASS || obs_q.size() != 2) begin
      fails++; $display("FAIL midpkt_pre got state %0d beats %0d exp PASS/2", state_dbg, obs_q.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (t_valid !== 1'b0 || t_last !== 1'b0 || src_ready !== '0 || active !== 1'b0 || state_dbg !== IDLE) begin
      fails++; $display("FAIL midpkt_reset_out got v %b l %b rdy %b act %b st %0d exp 0/0/0/0/IDLE", t_valid, t_last, src_ready, active, state_dbg); end
    tests++; if (frame_cnt !== '0 || trunc_cnt !== '0) begin
      fails++; $display("FAIL midpkt_reset_cnt got frame %h trunc %h exp 0", frame_cnt, trunc_cnt); end
    rst = 1'b0;
    sq[2].delete();
    drive_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    src_valid = '0; src_last = '0; src_data = '0;
    src_enable = '1; max_beats = '0; t_ready = 1'b1;
    toggle_rdy = 0; en_clr_cyc = -1; user_err = 0;
    clear_sb();
    test_reset();
    test_single();
    test_fairness();
    test_truncate();
    test_exact_limit();
    test_max_one();
    test_ready_toggle();
    test_enable_and_reset();
    tests++; if (user_err != 0) begin fails++; $display("FAIL tuser_high_bits got %0d nonzero samples exp 0", user_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_stream_arbiter.md
Name: dma_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 64-bit DMA inbound stream (dmaIbMaster_*) between NUM_SRC event producers (ldmx_daq-style readout blocks).
- Holds each grant from the first beat to the end-of-packet beat.
- Tags each packet with its source index on tDest.
- Enforces a runtime packet-length limit: an over-length packet is truncated and its remainder drained.
- Keeps per-source frame counters for the AXI-Lite status registers.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_W, 64, stream data width; matches the DMA configuration.
- CNT_W, 16, width of the beat counter and status counters.

Ports:
- dmaClk  in  1  DMA stream clock; all logic in this domain.
- dmaRst  in  1  reset; synchronous, active-high.
- src_valid  in  NUM_SRC  per-source beat valid.
- src_data  in  NUM_SRC*DATA_W  per-source beat data; source i occupies bits [i*DATA_W +: DATA_W].
- src_last  in  NUM_SRC  per-source end-of-packet.
- src_ready  out  NUM_SRC  per-source beat accepted.
- src_enable  in  NUM_SRC  arbitration enable mask from a config register.
- max_beats  in  CNT_W  packet length limit in beats; 0 = unlimited.
- dmaIbMaster_tValid  out  1  output beat valid.
- dmaIbMaster_tData  out  DATA_W  output beat data.
- dmaIbMaster_tLast  out  1  output end-of-packet.
- dmaIbMaster_tDest  out  8  granted source index, zero-extended.
- dmaIbMaster_tUser  out  64  bit0 = truncation error on the last beat; all other bits 0.
- dmaIbSlave_tReady  in  1  DMA engine ready.
- frame_cnt  out  NUM_SRC*CNT_W  packets delivered per source; wraps.
- trunc_cnt  out  CNT_W  truncated packets; saturates at all-ones.
- active  out  1  high while in PASS or DRAIN.

Behaviour:
- Reset:
  - State IDLE; grant index 0; round-robin pointer 0; beat counter 0.
  - All counters 0.
  - All outputs 0: tValid, tLast, tDest, tUser, src_ready, active.
  - Reset asserted mid-packet aborts immediately. No tLast is emitted; the packet is abandoned.
- States:
  - IDLE:
    - Request vector = src_valid & src_enable.
    - If non-zero, register the grant as the first requester found searching from (pointer+1) mod NUM_SRC upward, with wrap.
    - Clear the beat counter and go to PASS.
    - No beat is transferred in IDLE. The first beat of a packet transfers no earlier than the cycle after the grant.
  - PASS:
    - tValid = src_valid[g]; tData = src_data[g]; tDest = g; src_ready[g] = dmaIbSlave_tReady.
    - src_ready is 0 for every other source. This is a combinational ready path with no bubble.
    - A beat is accepted when tValid & tReady. Each accepted beat increments the beat counter.
    - limit_hit = (max_beats != 0) & (beat counter == max_beats-1).
    - tLast = src_last[g] | limit_hit. tUser[0] = limit_hit & ~src_last[g].
    - Accepted beat with src_last[g]=1: increment frame_cnt[g], set pointer = g, go to IDLE.
    - Accepted beat with limit_hit and src_last[g]=0: increment frame_cnt[g] and trunc_cnt, set pointer = g, go to DRAIN.
    - src_last coinciding with limit_hit counts as a normal end: tUser[0]=0, no trunc_cnt increment.
  - DRAIN:
    - src_ready[g]=1; tValid=0.
    - Source beats are discarded until an accepted beat with src_last[g]=1, then go to IDLE.
- A source disabled mid-packet still completes its current packet. src_enable is sampled only in IDLE.
- All sources disabled or idle: the block stays in IDLE with outputs 0.
- A single requester is re-granted repeatedly. There is one IDLE cycle between its packets.
- max_beats=1 produces one-beat packets; every multi-beat packet is truncated.
- max_beats is sampled live. Software changes it only while the block is stopped.
- Beat counter does not overflow: with max_beats=0, a beat count beyond 2^CNT_W wraps harmlessly.
- Fairness: with all NUM_SRC sources continuously requesting, grants cycle 0,1,2,3,0,...
- active = (state != IDLE).

Decomposition:
- Package ldmx_dma_pkg:
  - State encoding: IDLE, PASS, DRAIN.
  - DATA_W default and CNT_W default.
  - tUser bit index for truncation error.
  - tDest width (8).
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: request vector and pointer. Outputs: one-hot grant and binary index.
  - Reused by later multi-link merges.

Test Plan:
- Reset, then source 2 sends 4 beats 0x1..0x4 with last on beat 4, tReady=1 -> grant the cycle after valid; tDest=2; 4 output beats with tLast on 0x4 only; frame_cnt[2]=1; back to IDLE.
- Sources 0..3 each continuously send 2-beat packets -> output order by tDest is 0,1,2,3,0,1; each frame_cnt is 2 after 8 packets; one IDLE cycle between packets.
- max_beats=3; source 1 sends 6 beats -> 3 output beats, beat 3 has tLast=1 and tUser=1; beats 4-6 accepted with tValid=0; trunc_cnt=1; frame_cnt[1]=1.
- max_beats=3; source 1 sends exactly 3 beats with last on beat 3 -> tLast=1, tUser=0, trunc_cnt=0.
- tReady toggles 1,0,1,0 during a 4-beat packet -> src_ready mirrors tReady; no beat lost or duplicated; data in order.
- src_enable[0] cleared mid-packet from source 0 -> packet completes; source 0 then not granted while valid; dmaRst pulsed mid-packet -> next cycle all outputs 0, state IDLE, counters 0.
